// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants: default widths, reset vector, NOP encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Contents:
//   XLEN_DEFAULT     - default address / PC width
//   ILEN_DEFAULT     - default instruction width
//   RESET_PC_DEFAULT - default first fetch address
//   NOP_INSTR        - canonical NOP (addi x0, x0, 0)
//   PC_STEP          - fetch stride in bytes (fixed 32-bit instructions)
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN_DEFAULT = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous DEPTH-entry FIFO of {instr, pc} words with a flush input.
// Latency: a write is visible at the head the cycle after it is accepted.
// Backpressure: writes when full are accepted only alongside a read; reads when empty are ignored.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   flush           - empties the queue next cycle; dominates wr_en / rd_en
//   wr_en, wr_data  - enqueue request and payload
//   rd_en           - dequeue request (ignored when empty)
//   rd_data         - head entry (combinational read of storage)
//   count, empty    - occupancy and empty flag
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // A full queue may still take a write when the head leaves in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[head];

  // Storage carries no reset; validity is tracked purely by count.
  always_ff @(posedge clk) begin
    if (do_wr && !rst && !flush) begin
      mem[tail] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_wr) begin
        tail <= tail + AW'(1);
      end
      if (do_rd) begin
        head <= head + AW'(1);
      end
      if (do_wr && !do_rd) begin
        count <= count + CW'(1);
      end else if (!do_wr && do_rd) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: sequential PC, fixed-latency imem, decode-side instruction queue.
// Latency: request to out_valid is exactly 2 cycles; redirect to first new request is 1 cycle.
// Backpressure: fetch throttles so queued plus in-flight entries never exceed DEPTH.
//
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   imem_req, imem_addr          - fetch request and address (address is the PC register)
//   imem_rdata                   - instruction returned one cycle after imem_req
//   redirect_valid, redirect_pc  - flush and restart fetch at redirect_pc (word aligned)
//   out_valid, out_ready         - decode handshake; transfer when both high
//   out_instr, out_pc            - head-of-queue instruction and its PC
//   count                        - queue occupancy (excludes the in-flight response)
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEFAULT,
  parameter int               ILEN     = ILEN_DEFAULT,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req,
  output logic [XLEN-1:0]         imem_addr,
  input  logic [ILEN-1:0]         imem_rdata,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ILEN-1:0]         out_instr,
  output logic [XLEN-1:0]         out_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int CW = $clog2(DEPTH) + 1;
  // One extra bit so count + inflight cannot wrap when count == DEPTH.
  localparam int OW = CW + 1;
  localparam int EW = ILEN + XLEN;

  logic [XLEN-1:0] pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;

  logic            deq;
  logic            enq;
  logic [OW-1:0]   occupancy;
  logic [XLEN-1:0] redirect_target;
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   head_entry;
  logic            fifo_empty;
  logic            unused_redirect_lsbs;

  assign imem_addr = pc;

  assign deq = out_valid && out_ready;

  // Slots that will be taken once everything already requested has landed,
  // crediting the entry decode is taking this cycle.
  assign occupancy = {1'b0, count} + OW'(inflight) - OW'(deq);

  assign imem_req = !rst && !redirect_valid && (occupancy < OW'(DEPTH));

  // A response arriving in a redirect cycle belongs to the old path.
  assign enq = inflight && !redirect_valid;

  assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  assign wr_entry = {imem_rdata, inflight_pc};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_target;
    end else if (imem_req) begin
      pc <= pc + XLEN'(PC_STEP);
    end
  end

  // Remember which PC the outstanding response belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= pc;
      end
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_instr_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .wr_en   (enq),
    .wr_data (wr_entry),
    .rd_en   (out_ready),
    .rd_data (head_entry),
    .count   (count),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = head_entry[XLEN-1:0];
  // Present a NOP rather than stale storage when nothing is queued.
  assign out_instr = out_valid ? head_entry[EW-1:XLEN] : ILEN'(NOP_INSTR);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomised bench for fetch_queue with a PC-stream scoreboard.
// Latency: n/a.
// Backpressure: out_ready driven by the stimulus.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [31:0] out_instr2;
  logic [31:0] out_pc2;
  logic [2:0]  count2;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] sb[$];
  logic [31:0] exp_fetch = 32'h0;
  logic        tb_inflight = 1'b0;
  logic        m_deq;
  logic        m_req;
  logic [3:0]  m_occ;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  fetch_queue #(
    .XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .count(count)
  );

  fetch_queue #(
    .XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)
  ) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_instr(out_instr2), .out_pc(out_pc2), .count(count2)
  );

  // Memory answers every address one cycle later with addr ^ A5A5A5A5.
  always @(posedge clk) begin
    imem_rdata  <= imem_addr  ^ 32'hA5A5_A5A5;
    imem_rdata2 <= imem_addr2 ^ 32'hA5A5_A5A5;
  end

  always @(posedge clk) begin
    tb_inflight <= rst ? 1'b0 : imem_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every issued request pushes its address; every decode
  // transfer pops the oldest; reset and redirect discard everything pending.
  always @(negedge clk) begin
    m_deq = out_valid && out_ready;
    m_occ = {1'b0, count} + {3'b0, tb_inflight} - {3'b0, m_deq};
    m_req = !rst && !redirect_valid && (m_occ < 4'd4);
    chk("mon_imem_req", {31'b0, imem_req}, {31'b0, m_req});
    chk("mon_count_bound", {31'b0, (count <= 3'd4)}, 32'd1);
    chk("mon_out_valid", {31'b0, out_valid}, {31'b0, (count != 3'd0)});
    if (!rst && m_deq) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL mon_unexpected_out observed=%h expected=none", out_pc);
      end
      if (sb.size() != 0) begin
        m_pc = sb.pop_front();
        chk("mon_out_pc", out_pc, m_pc);
        chk("mon_out_instr", out_instr, m_pc ^ 32'hA5A5_A5A5);
      end
    end
    if (rst) begin
      sb.delete();
      exp_fetch = 32'h0;
    end else if (redirect_valid) begin
      sb.delete();
      exp_fetch = {redirect_pc[31:2], 2'b00};
    end else if (imem_req) begin
      chk("mon_imem_addr", imem_addr, exp_fetch);
      sb.push_back(exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #2;
  endtask

  initial begin
    rst            = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    nxt(); nxt(); smp();
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);

    // Streaming from reset with decode always ready
    nxt(); rst = 1'b0; smp();
    chk("c0_imem_req", {31'b0, imem_req}, 32'd1);
    chk("c0_imem_addr", imem_addr, 32'h0);
    chk("c0_out_valid", {31'b0, out_valid}, 32'd0);
    nxt(); smp();
    chk("c1_imem_addr", imem_addr, 32'h4);
    chk("c1_out_valid", {31'b0, out_valid}, 32'd0);
    chk("wrap_c1_out_valid", {31'b0, out_valid2}, 32'd0);
    nxt(); smp();
    chk("c2_out_valid", {31'b0, out_valid}, 32'd1);
    chk("c2_out_pc", out_pc, 32'h0);
    chk("c2_out_instr", out_instr, 32'hA5A5_A5A5);
    chk("c2_count", {29'b0, count}, 32'd1);
    chk("c2_imem_addr", imem_addr, 32'h8);
    chk("wrap_c2_out_pc", out_pc2, 32'hFFFF_FFF8);
    nxt(); smp();
    chk("c3_out_pc", out_pc, 32'h4);
    chk("wrap_c3_out_pc", out_pc2, 32'hFFFF_FFFC);
    nxt(); smp();
    chk("c4_out_pc", out_pc, 32'h8);
    chk("wrap_c4_out_pc", out_pc2, 32'h0000_0000);
    chk("wrap_c4_out_instr", out_instr2, 32'hA5A5_A5A5);
    nxt(); smp();
    chk("c5_out_pc", out_pc, 32'hC);
    chk("wrap_c5_out_pc", out_pc2, 32'h0000_0004);

    // One-cycle reset mid-stream with a response in flight, then stall decode
    nxt(); rst = 1'b1; smp();
    chk("midrst_imem_req", {31'b0, imem_req}, 32'd0);
    nxt(); rst = 1'b0; out_ready = 1'b0; smp();
    chk("midrst_count", {29'b0, count}, 32'd0);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_imem_addr", imem_addr, 32'h0);
    for (int i = 1; i <= 10; i++) begin
      nxt(); smp();
      if (i == 2) chk("stall_first_pc", out_pc, 32'h0);
      if (i == 4) chk("stall_count3", {29'b0, count}, 32'd3);
      if (i >= 5) begin
        chk("stall_count_full", {29'b0, count}, 32'd4);
        chk("stall_no_req", {31'b0, imem_req}, 32'd0);
      end
      if (i == 10) chk("stall_pc_held", out_pc, 32'h0);
    end

    // Release decode: in-order resume, then redirect with dequeue and enqueue
    nxt(); out_ready = 1'b1; smp();
    chk("release_req", {31'b0, imem_req}, 32'd1);
    chk("release_pc", out_pc, 32'h0);
    nxt(); smp();
    chk("release_count", {29'b0, count}, 32'd3);
    chk("release_pc2", out_pc, 32'h4);
    nxt(); redirect_valid = 1'b1; redirect_pc = 32'h200; smp();
    chk("redir_deq_count", {29'b0, count}, 32'd3);
    chk("redir_deq_pc", out_pc, 32'h8);
    chk("redir_no_req", {31'b0, imem_req}, 32'd0);
    nxt(); redirect_pc = 32'h300; smp();
    chk("redir_empty_count", {29'b0, count}, 32'd0);
    chk("redir_empty_valid", {31'b0, out_valid}, 32'd0);
    chk("redir_addr_200", imem_addr, 32'h200);
    nxt(); redirect_pc = 32'h406; smp();
    chk("redir_addr_300", imem_addr, 32'h300);
    nxt(); redirect_valid = 1'b0; smp();
    chk("b2b_addr", imem_addr, 32'h404);
    chk("b2b_req", {31'b0, imem_req}, 32'd1);
    nxt(); smp();
    chk("b2b_wait_valid", {31'b0, out_valid}, 32'd0);
    nxt(); smp();
    chk("b2b_out_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_out_pc", out_pc, 32'h404);
    chk("b2b_out_instr", out_instr, 32'h404 ^ 32'hA5A5_A5A5);

    // Redirect to an unaligned target with three queued and one in flight
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0; out_ready = 1'b0; smp();
    chk("r35_c0_addr", imem_addr, 32'h0);
    repeat (4) nxt();
    redirect_valid = 1'b1; redirect_pc = 32'h103; smp();
    chk("r35_count3", {29'b0, count}, 32'd3);
    nxt(); redirect_valid = 1'b0; smp();
    chk("r35_count0", {29'b0, count}, 32'd0);
    chk("r35_valid0", {31'b0, out_valid}, 32'd0);
    chk("r35_addr", imem_addr, 32'h100);
    chk("r35_req", {31'b0, imem_req}, 32'd1);
    nxt(); smp();
    chk("r35_wait_valid", {31'b0, out_valid}, 32'd0);
    nxt(); out_ready = 1'b1; smp();
    chk("r35_out_valid", {31'b0, out_valid}, 32'd1);
    chk("r35_out_pc", out_pc, 32'h100);

    // Random ready / redirect / reset traffic under the scoreboard
    for (int n = 0; n < 10000; n++) begin
      nxt();
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 31) == 0);
      redirect_pc    = $urandom;
      rst            = ($urandom_range(0, 199) == 0);
    end
    nxt();
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    repeat (8) nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
